// File: rtl/logic_gate_seq_if.sv
// Handshake/operand bundle for logic_gate_seq: input beat channel plus
// registered result channel.
interface logic_gate_seq_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             acc_en;
   logic             last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             y_all1;
   logic             y_any1;
   logic [CNT_W-1:0] beat_cnt;

   modport master (
      output in_valid, a, b, op, acc_en, last, out_ready,
      input  in_ready, out_valid, y, y_all1, y_any1, beat_cnt
   );

   modport slave (
      input  in_valid, a, b, op, acc_en, last, out_ready,
      output in_ready, out_valid, y, y_all1, y_any1, beat_cnt
   );
endinterface

// File: rtl/logic_gate_seq.sv
// Registered bitwise gate (AND/OR/XOR/PASS, optional invert) with N-input
// accumulation over bursts and a single-entry valid/ready output register.
module logic_gate_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   logic_gate_seq_if.slave bus
);
   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [2:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_all1;
   logic             r_any1;
   logic [CNT_W-1:0] r_beat_cnt;

   logic             w_in_ready;
   logic             w_fire;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_fold;
   logic [WIDTH-1:0] w_single;
   logic             w_res_vld;
   logic [WIDTH-1:0] w_res;
   logic [CNT_W-1:0] w_res_cnt;

   function automatic logic [WIDTH-1:0] f_base(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
      case (sel)
         2'd0:    return x & z;
         2'd1:    return x | z;
         2'd2:    return x ^ z;
         default: return z;
      endcase
   endfunction

   // The output register is the only buffer, so a slot opens only when it is
   // empty or being drained this cycle.
   always_comb begin
      w_in_ready = !rst && (!r_out_valid || bus.out_ready);
      w_fire     = bus.in_valid && w_in_ready;
      w_cnt_nxt  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
      w_fold     = f_base(r_op[1:0], r_acc, bus.a);
      w_single   = {WIDTH{bus.op[2]}} ^ f_base(bus.op[1:0], bus.b, bus.a);
      w_res_vld  = 1'b0;
      w_res      = '0;
      w_res_cnt  = '0;
      if (w_fire) begin
         case (r_state)
            S_IDLE: begin
               if (!bus.acc_en) begin
                  w_res_vld = 1'b1;
                  w_res     = w_single;
                  w_res_cnt = CNT_ONE;
               end else if (bus.last) begin
                  w_res_vld = 1'b1;
                  w_res     = {WIDTH{bus.op[2]}} ^ bus.a;
                  w_res_cnt = CNT_ONE;
               end
            end
            default: begin
               if (bus.last) begin
                  w_res_vld = 1'b1;
                  w_res     = {WIDTH{r_op[2]}} ^ w_fold;
                  w_res_cnt = w_cnt_nxt;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_all1      <= 1'b0;
         r_any1      <= 1'b0;
         r_beat_cnt  <= '0;
      end else begin
         if (w_fire) begin
            case (r_state)
               S_IDLE: begin
                  if (bus.acc_en && !bus.last) begin
                     r_acc   <= bus.a;
                     r_op    <= bus.op;
                     r_cnt   <= CNT_ONE;
                     r_state <= S_ACCUM;
                  end
               end
               default: begin
                  if (bus.last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_acc <= w_fold;
                     r_cnt <= w_cnt_nxt;
                  end
               end
            endcase
         end
         if (w_res_vld) begin
            r_out_valid <= 1'b1;
            r_y         <= w_res;
            r_all1      <= &w_res;
            r_any1      <= |w_res;
            r_beat_cnt  <= w_res_cnt;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.y         = r_y;
   assign bus.y_all1    = r_all1;
   assign bus.y_any1    = r_any1;
   assign bus.beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_logic_gate_seq.sv
// Directed bench for logic_gate_seq: single ops, bursts, back-pressure,
// streaming, mid-burst reset and counter saturation.
module tb_logic_gate_seq;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   logic_gate_seq_if #(.WIDTH(8), .CNT_W(4)) bus ();

   logic_gate_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic acc_en, input logic last);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.acc_en   = acc_en;
      bus.last     = last;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", bus.y); end
      checks++;
      if (bus.beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt got=%0d exp=0", bus.beat_cnt); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_single_and();
      bus.out_ready = 1'b1;
      set_beat(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'h30) begin
         errors++; $display("FAIL single_and got v=%b y=%h exp v=1 y=30", bus.out_valid, bus.y);
      end
      checks++;
      if (bus.beat_cnt !== 4'd1 || bus.y_any1 !== 1'b1 || bus.y_all1 !== 1'b0) begin
         errors++; $display("FAIL single_and_flags got cnt=%0d any=%b all=%b exp 1/1/0",
                            bus.beat_cnt, bus.y_any1, bus.y_all1);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_all_ops();
      logic [7:0] exp_y [8];
      exp_y = '{8'h05, 8'hAF, 8'hAA, 8'hA5, 8'hFA, 8'h50, 8'h55, 8'h5A};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_beat(3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0);
         tick();
         bus.in_valid = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.y !== exp_y[i]) begin
            errors++; $display("FAIL op%0d got v=%b y=%h exp y=%h", i, bus.out_valid, bus.y, exp_y[i]);
         end
         tick();
      end
      // all-ones result lights y_all1
      set_beat(3'd1, 8'hF0, 8'h0F, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.y !== 8'hFF || bus.y_all1 !== 1'b1) begin
         errors++; $display("FAIL all1 got y=%h all=%b exp FF/1", bus.y, bus.y_all1);
      end
      tick();
   endtask

   task automatic test_burst();
      bus.out_ready = 1'b1;
      set_beat(3'd4, 8'hFF, 8'h00, 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL burst_mid1 got v=%b exp=0", bus.out_valid); end
      // op and acc_en changes mid-burst must be ignored
      set_beat(3'd1, 8'hF0, 8'hFF, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL burst_mid2 got v=%b exp=0", bus.out_valid); end
      set_beat(3'd3, 8'h3C, 8'hAA, 1'b0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'hCF || bus.beat_cnt !== 4'd3) begin
         errors++; $display("FAIL burst_nand got v=%b y=%h cnt=%0d exp y=CF cnt=3",
                            bus.out_valid, bus.y, bus.beat_cnt);
      end
      tick();
      // PASS-with-invert burst keeps only the last beat
      set_beat(3'd7, 8'h11, 8'h00, 1'b1, 1'b0); tick();
      set_beat(3'd0, 8'h22, 8'h00, 1'b1, 1'b0); tick();
      set_beat(3'd0, 8'h33, 8'h00, 1'b1, 1'b1); tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.y !== 8'hCC || bus.beat_cnt !== 4'd3) begin
         errors++; $display("FAIL burst_pass got y=%h cnt=%0d exp CC/3", bus.y, bus.beat_cnt);
      end
      tick();
      // one-beat burst is a single-input gate
      set_beat(3'd4, 8'h3C, 8'hFF, 1'b1, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.y !== 8'hC3 || bus.beat_cnt !== 4'd1) begin
         errors++; $display("FAIL burst_one got y=%h cnt=%0d exp C3/1", bus.y, bus.beat_cnt);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      set_beat(3'd2, 8'hA5, 8'h0F, 1'b0, 1'b0);
      tick();
      set_beat(3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.y !== 8'hAA || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d got v=%b y=%h rdy=%b exp 1/AA/0",
                               i, bus.out_valid, bus.y, bus.in_ready);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'h03 || bus.beat_cnt !== 4'd1) begin
         errors++; $display("FAIL bp_next got v=%b y=%h cnt=%0d exp 1/03/1",
                            bus.out_valid, bus.y, bus.beat_cnt);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got v=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ev;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_beat(3'd2, 8'(i * 17), 8'h5A, 1'b0, 1'b0);
         ev = 8'(i * 17) ^ 8'h5A;
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.y !== ev) begin
            errors++; $display("FAIL stream%0d got v=%b y=%h exp y=%h", i, bus.out_valid, bus.y, ev);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got v=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_reset_mid_burst();
      bus.out_ready = 1'b1;
      set_beat(3'd0, 8'h0F, 8'h00, 1'b1, 1'b0); tick();
      set_beat(3'd0, 8'h03, 8'h00, 1'b1, 1'b0); tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
      set_beat(3'd1, 8'h81, 8'h00, 1'b1, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'h81 || bus.beat_cnt !== 4'd1) begin
         errors++; $display("FAIL mid_rst_new got v=%b y=%h cnt=%0d exp 1/81/1",
                            bus.out_valid, bus.y, bus.beat_cnt);
      end
      tick();
   endtask

   task automatic test_saturation();
      logic [7:0] ev;
      bus.out_ready = 1'b1;
      ev = 8'h00;
      for (int i = 0; i < 20; i++) begin
         set_beat(3'd2, 8'(i * 7 + 1), 8'h00, 1'b1, (i == 19));
         ev = ev ^ 8'(i * 7 + 1);
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== ev || bus.beat_cnt !== 4'd15) begin
         errors++; $display("FAIL sat got v=%b y=%h cnt=%0d exp y=%h cnt=15",
                            bus.out_valid, bus.y, bus.beat_cnt, ev);
      end
      tick();
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.acc_en    = 1'b0;
      bus.last      = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single_and();
      test_all_ops();
      test_burst();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_burst();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
